// File: rtl/rr_mux_nto1.sv
// -----------------------------------------------------------------------------
// rr_mux_nto1
// Registered N:1 round-robin collector. Merges N valid/ready input channels
// into a single output stream. Each output beat carries the index of the
// channel it came from on out_sel, so a downstream 1:N demux can route it
// back to the same channel.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   [N]     per-channel valid
//   in_data    [N*W]   packed channel data, channel i = in_data[i*W +: W]
//   in_ready   [N]     per-channel accept, one-hot or zero
//   out_valid          output register holds a beat
//   out_data   [W]     beat payload
//   out_sel    [SW]    source channel index of the beat
//   out_ready          consumer accepts when out_valid && out_ready
// -----------------------------------------------------------------------------
module rr_mux_nto1 #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  // N expressed at index-plus-carry width, used to wrap ptr+k back below N.
  localparam logic [SW:0] N_IDX  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N-1);

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_ptr;

  logic          w_load_en;
  logic          w_found;
  logic [SW-1:0] w_grant;
  logic [SW-1:0] w_ptr_next;
  logic [W-1:0]  w_grant_data;
  logic [N-1:0]  w_ready;

  // The output register can take a new beat when it is empty, or when the
  // beat it holds leaves this cycle (drain and refill together).
  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin search: visit ptr, ptr+1, ... wrapping at N, take the first
  // valid channel. ptr+k never exceeds 2N-2, so one conditional subtract wraps.
  always_comb begin
    logic [SW:0] v_idx;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    w_found = 1'b0;
    w_grant = '0;
    v_idx   = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = {1'b0, r_ptr} + (SW+1)'(k);
      if (v_idx >= N_IDX) v_idx = v_idx - N_IDX;
      if (!w_found && in_valid[v_idx[SW-1:0]]) begin
        w_found = 1'b1;
        w_grant = v_idx[SW-1:0];
      end
    end
  end

  always_comb begin
    w_grant_data = in_data[w_grant*W +: W];
    w_ptr_next   = (w_grant == LAST) ? '0 : w_grant + 1'b1;
  end

  // Accept only the granted channel, and only when the register can load.
  always_comb begin
    w_ready = '0;
    if (w_found && w_load_en) w_ready[w_grant] = 1'b1;
  end

  assign in_ready = w_ready;

  // Output register FSM: state is r_out_valid (EMPTY/FULL). When it cannot
  // load (FULL and stalled) everything, including ptr, holds.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_sel   <= w_grant;
        r_ptr       <= w_ptr_next;
      end else begin
        // Drained with nothing to refill: payload and index keep last values.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_nto1.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_nto1
// Self-checking bench for rr_mux_nto1 (N=8, W=8). A behavioural model tracks
// the output beat and round-robin pointer; every cycle the DUT outputs and
// in_ready are compared with it. Directed sequences add literal expectations,
// then a randomized phase drives protocol-respecting producers.
// -----------------------------------------------------------------------------
module tb_rr_mux_nto1;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  rr_mux_nto1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the output register and pointer must hold.
  int m_valid = 0;
  int m_data  = 0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_exp_ready = 0;          // in_ready the model expects this cycle
  logic [N-1:0] last_ready;     // DUT in_ready sampled in the last step

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the
  // model across the rising edge. Returns 1 ns after the rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic ordy, input logic r);
    int g;
    int load_en;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    // Round-robin choice from the rules: first valid index at or after ptr.
    g = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (g < 0 && v[c]) g = c;
    end
    load_en     = (m_valid == 0) || ordy;
    m_exp_ready = (g >= 0 && load_en != 0) ? (1 << g) : 0;
    last_ready  = in_ready;
    check("in_ready",  {56'd0, in_ready},  64'(m_exp_ready));
    check("out_valid", {63'd0, out_valid}, 64'(m_valid));
    check("out_data",  {56'd0, out_data},  64'(m_data));
    check("out_sel",   {61'd0, out_sel},   64'(m_sel));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (load_en != 0) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = int'(d[g*W +: W]);
        m_sel   = g;
        m_ptr   = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  function automatic logic [N*W-1:0] ramp_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(8'h10 + i);
    return d;
  endfunction

  logic [N-1:0]   pv;
  logic [N*W-1:0] pd;
  logic [N*W-1:0] ramp;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    ramp = ramp_data();

    // Reset hold: nothing moves.
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 1'b1, 1'b1);
      check("rst_hold_valid", {63'd0, out_valid}, 64'd0);
      check("rst_hold_sel",   {61'd0, out_sel},   64'd0);
      check("rst_hold_ready", {56'd0, last_ready}, 64'h00);
    end
    step('0, '0, 1'b1, 1'b0);

    // Single channel 5.
    pd = '0; pd[5*W +: W] = 8'hA5;
    step(8'b0010_0000, pd, 1'b1, 1'b0);
    check("ch5_ready", {56'd0, last_ready}, 64'h20);
    check("ch5_valid", {63'd0, out_valid},  64'd1);
    check("ch5_data",  {56'd0, out_data},   64'hA5);
    check("ch5_sel",   {61'd0, out_sel},    64'd5);
    step('0, pd, 1'b1, 1'b0);
    check("ch5_drain", {63'd0, out_valid}, 64'd0);

    // All channels valid from a fresh pointer: 0..7,0,1 with no bubbles.
    step('0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step('1, ramp, 1'b1, 1'b0);
      check("rr_valid", {63'd0, out_valid}, 64'd1);
      check("rr_sel",   {61'd0, out_sel},   64'(i % N));
      check("rr_data",  {56'd0, out_data},  64'(8'h10 + (i % N)));
    end

    // Backpressure with beat 3 held, then drain+refill from channel 4.
    step('0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step('1, ramp, 1'b1, 1'b0);
    check("bp_sel_start", {61'd0, out_sel}, 64'd3);
    for (int i = 0; i < 4; i++) begin
      step('1, ramp, 1'b0, 1'b0);
      check("bp_ready", {56'd0, last_ready}, 64'h00);
      check("bp_sel",   {61'd0, out_sel},    64'd3);
      check("bp_data",  {56'd0, out_data},   64'h13);
      check("bp_valid", {63'd0, out_valid},  64'd1);
    end
    step('1, ramp, 1'b1, 1'b0);
    check("bp_release_ready", {56'd0, last_ready}, 64'h10);
    check("bp_release_sel",   {61'd0, out_sel},    64'd4);
    check("bp_release_data",  {56'd0, out_data},   64'h14);
    step('0, ramp, 1'b1, 1'b0);

    // Wrap: channels 2 and 6, last grant 6.
    step('0, '0, 1'b1, 1'b1);
    step(8'b0100_0000, ramp, 1'b1, 1'b0);
    check("wrap_first", {61'd0, out_sel}, 64'd6);
    for (int i = 0; i < 4; i++) begin
      step(8'b0100_0100, ramp, 1'b1, 1'b0);
      check("wrap_sel", {61'd0, out_sel}, (i % 2 == 0) ? 64'd2 : 64'd6);
    end
    step('0, ramp, 1'b1, 1'b0);

    // Reset while FULL with ptr=5, then channels 1 and 6 -> channel 1 first.
    step('0, '0, 1'b1, 1'b1);
    step(8'b0001_0000, ramp, 1'b1, 1'b0);
    check("mid_pre_sel", {61'd0, out_sel}, 64'd4);
    step('0, ramp, 1'b0, 1'b1);
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_sel",   {61'd0, out_sel},   64'd0);
    step(8'b0100_0010, ramp, 1'b1, 1'b0);
    check("mid_after_ready", {56'd0, last_ready}, 64'h02);
    check("mid_after_sel",   {61'd0, out_sel},    64'd1);
    check("mid_after_data",  {56'd0, out_data},   64'h11);

    // Randomized traffic: producers hold valid/data until the model says
    // the beat was accepted; the consumer stalls about 30% of cycles.
    pv = '0; pd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 40) begin
          pv[i] = 1'b1;
          pd[i*W +: W] = W'($urandom);
        end
      end
      step(pv, pd, ($urandom_range(0, 99) < 70), 1'b0);
      pv = pv & ~N'(m_exp_ready);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
